zx_mem_pager: RTL

- Parametrised memory/IO mapper that generalises the 48K ULA write-latch and loader-override logic.
- Adds 128K-style paging through port 0x7FFD, with a configurable bank count and a lock bit.
- Adds a loader/CPU-control FSM driven by SPI control writes.
- Sits between the tv80n bus, the SPI slave and the dual-port RAM. It produces the physical RAM address and write enable, border/sound/mic state, and the CPU reset/wait controls.

---
 rtl/zx_pkg.sv | 33 +++
 rtl/zx_io_edge.sv | 22 ++
 rtl/zx_mem_pager.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/zx_pkg.sv
// Shared constants for the ZX memory/IO pager: page numbering, port decode
// masks, control-register bit positions and the loader FSM state type.
package zx_pkg;

    localparam int PG_ROM0      = 0;
    localparam int PG_ROM1      = 1;
    localparam int PG_BANK_BASE = 2;

    // Fixed banks behind the 4000-7FFF and 8000-BFFF windows
    localparam int BANK_SCREEN = 5;
    localparam int BANK_MID    = 2;

    // A port matches when every address bit selected by its mask is zero
    localparam logic [15:0] ULA_PORT_MASK = 16'h0001;
    localparam logic [15:0] PG_PORT_MASK  = 16'h8002;

    localparam logic [7:0] SPI_SEL_RAM  = 8'h00;
    localparam logic [7:0] SPI_SEL_CTRL = 8'hFF;

    localparam int CTRL_RESET = 0;
    localparam int CTRL_LOAD  = 1;

    typedef enum logic [1:0] {
        RUN,
        LOAD,
        HOLD
    } pager_state_e;

    function automatic logic port_hit(input logic [15:0] addr, input logic [15:0] mask);
        return (addr & mask) == 16'h0000;
    endfunction

endpackage

// File: rtl/zx_io_edge.sv
// Registered rising-edge detector for an IO write strobe: one pulse per
// assertion no matter how many cycles the CPU holds the strobe.
module zx_io_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe_i,
    output logic rise_o
);

    logic old_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            old_q <= 1'b0;
        end else begin
            old_q <= strobe_i;
        end
    end

    assign rise_o = strobe_i & ~old_q;

endmodule

// File: rtl/zx_mem_pager.sv
// ZX memory/IO mapper: ULA latch, 7FFD paging, physical RAM mapping and the
// SPI-driven loader/CPU-control FSM. Optional macro: PAGE_7FFD_READBACK_EN.
module zx_mem_pager
    import zx_pkg::*;
#(
    parameter int MODE       = 1,
    parameter int NUM_BANKS  = 8,
    parameter int RESET_HOLD = 16,
    parameter int PAGE_W     = $clog2(NUM_BANKS + 2)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [15:0]          cpu_addr,
    input  logic [7:0]           cpu_dout,
    input  logic                 n_mreq,
    input  logic                 n_iorq,
    input  logic                 n_wr,
    input  logic                 n_m1,
    input  logic                 spi_wr,
    input  logic [31:0]          spi_addr,
    input  logic [7:0]           spi_data,
    output logic [PAGE_W+13:0]   ram_addr,
    output logic                 ram_we,
    output logic [7:0]           ram_din,
    output logic [2:0]           border_color,
    output logic                 sound,
    output logic                 mic,
    output logic                 screen_sel,
    output logic                 paging_locked,
`ifdef PAGE_7FFD_READBACK_EN
    output logic                 pg_rd_hit,
    output logic [7:0]           pg_rdata,
`endif
    output logic                 cpu_reset_n,
    output logic                 cpu_wait_n
);

    localparam int CNT_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    logic [2:0]        border_q;
    logic              sound_q;
    logic              mic_q;
    logic [5:0]        pg_q;
    logic [7:0]        ctrl_q;
    pager_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              ula_we, ula_rise;
    logic              pg_we, pg_rise;
    logic              rom_sel;
    logic [PAGE_W-1:0] bank_idx;
    logic [PAGE_W-1:0] cpu_page;
    logic              unused_spi_bits;

    assign ula_we = port_hit(cpu_addr, ULA_PORT_MASK) & ~n_iorq & ~n_wr & n_m1;
    assign pg_we  = (MODE != 0) & port_hit(cpu_addr, PG_PORT_MASK) & ~n_iorq & ~n_wr & n_m1;

    zx_io_edge u_ula_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .strobe_i (ula_we),
        .rise_o   (ula_rise)
    );

    zx_io_edge u_pg_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .strobe_i (pg_we),
        .rise_o   (pg_rise)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            border_q <= 3'd0;
            mic_q    <= 1'b0;
            sound_q  <= 1'b0;
        end else if (ula_rise) begin
            border_q <= cpu_dout[2:0];
            mic_q    <= cpu_dout[3];
            sound_q  <= cpu_dout[4];
        end
    end

    // HOLD wipes paging and the lock so a reset CPU always boots from ROM0/bank0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pg_q <= 6'd0;
        end else if (state_q == HOLD) begin
            pg_q <= 6'd0;
        end else if (pg_rise && !pg_q[5]) begin
            pg_q <= cpu_dout[5:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q <= 8'h00;
        end else if (spi_wr && spi_addr[31:24] == SPI_SEL_CTRL) begin
            ctrl_q <= spi_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        cpu_reset_n = 1'b1;
        cpu_wait_n  = 1'b1;
        case (state_q)
            RUN: begin
                if (ctrl_q[CTRL_RESET])     state_d = HOLD;
                else if (ctrl_q[CTRL_LOAD]) state_d = LOAD;
            end
            LOAD: begin
                cpu_wait_n = 1'b0;
                if (ctrl_q[CTRL_RESET])      state_d = HOLD;
                else if (!ctrl_q[CTRL_LOAD]) state_d = RUN;
            end
            HOLD: begin
                cpu_reset_n = 1'b0;
                // Counter saturates so a still-asserted reset request keeps us here
                if (cnt_q == CNT_W'(RESET_HOLD - 1)) begin
                    cnt_d = cnt_q;
                    if (!ctrl_q[CTRL_RESET]) state_d = ctrl_q[CTRL_LOAD] ? LOAD : RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign rom_sel  = (MODE != 0) ? pg_q[4] : 1'b0;
    assign bank_idx = PAGE_W'(32'(pg_q[2:0]) % NUM_BANKS);

    always_comb begin
        case (cpu_addr[15:14])
            2'b00:   cpu_page = rom_sel ? PAGE_W'(PG_ROM1) : PAGE_W'(PG_ROM0);
            2'b01:   cpu_page = PAGE_W'(PG_BANK_BASE + BANK_SCREEN);
            2'b10:   cpu_page = PAGE_W'(PG_BANK_BASE + BANK_MID);
            default: cpu_page = (MODE != 0) ? PAGE_W'(PG_BANK_BASE) + bank_idx
                                            : PAGE_W'(PG_BANK_BASE);
        endcase
    end

    // The loader owns the RAM port outright while the CPU is stalled
    always_comb begin
        ram_addr = {cpu_page, cpu_addr[13:0]};
        ram_din  = cpu_dout;
        ram_we   = ~n_mreq & ~n_wr & (cpu_page >= PAGE_W'(PG_BANK_BASE));
        if (state_q == LOAD) begin
            ram_addr = spi_addr[PAGE_W+13:0];
            ram_din  = spi_data;
            ram_we   = spi_wr & (spi_addr[31:24] == SPI_SEL_RAM);
        end
    end

    assign unused_spi_bits = ^spi_addr[23:PAGE_W+14];

    assign border_color  = border_q;
    assign sound         = sound_q;
    assign mic           = mic_q;
    assign screen_sel    = pg_q[3];
    assign paging_locked = pg_q[5];

`ifdef PAGE_7FFD_READBACK_EN
    assign pg_rd_hit = (MODE != 0) & port_hit(cpu_addr, PG_PORT_MASK) & ~n_iorq & n_wr & n_m1;
    assign pg_rdata  = {2'b00, pg_q};
`endif

endmodule
